// File: rtl/simproc_loader.sv
// rtl/simproc_loader.sv - program loader, memory owner and run controller for the simproc core
module simproc_loader #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int MAX_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          clear,
    input  logic [AW-1:0] proc_addr,
    input  logic [DW-1:0] proc_wdata,
    input  logic          proc_we,
    output logic [DW-1:0] proc_rdata,
    output logic [AW-1:0] pc_set_val,
    output logic          pc_set_wr,
    output logic          run,
    input  logic          proc_done,
    input  logic          proc_halt,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic [15:0]   cycle_count
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        S_LOAD_ADDR,
        S_LOAD_LEN,
        S_LOAD_DATA,
        S_SET_PC,
        S_RUN,
        S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] mem [0:DEPTH-1];

    logic [AW-1:0] start_addr;
    logic [AW-1:0] ptr;
    logic [AW:0]   remaining;
    logic [15:0]   cnt;
    logic          timeout_q;

    logic          accept;
    logic          take;
    logic [AW:0]   len_val;
    logic [16:0]   cnt_plus;
    logic          wd_hit;
    logic          core_stop;
    logic          load_we;
    logic          proc_wr_en;

    assign accept     = in_valid && in_ready;
    // A clear coinciding with an accept consumes the byte without using it.
    assign take       = accept && !clear;
    // A length byte of zero stands for a full memory image.
    assign len_val    = (in_data == '0) ? {1'b1, {AW{1'b0}}} : (AW+1)'(in_data);
    assign cnt_plus   = {1'b0, cnt} + 17'd1;
    assign wd_hit     = (cnt_plus == 17'(MAX_CYCLES));
    assign core_stop  = proc_done || proc_halt;
    assign load_we    = (state == S_LOAD_DATA) && take;
    assign proc_wr_en = (state == S_RUN) && proc_we;

    assign proc_rdata  = mem[proc_addr];
    assign pc_set_val  = start_addr;
    assign cycle_count = cnt;
    assign timeout     = timeout_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOAD_ADDR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state output strobes.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        pc_set_wr = 1'b0;
        run       = 1'b0;
        busy      = 1'b1;
        finished  = 1'b0;
        case (state)
            S_LOAD_ADDR: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (take) begin
                    state_nxt = S_LOAD_LEN;
                end
            end
            S_LOAD_LEN: begin
                in_ready = 1'b1;
                if (clear) begin
                    state_nxt = S_LOAD_ADDR;
                end else if (accept) begin
                    state_nxt = S_LOAD_DATA;
                end
            end
            S_LOAD_DATA: begin
                in_ready = 1'b1;
                if (clear) begin
                    state_nxt = S_LOAD_ADDR;
                end else if (accept && (remaining == (AW+1)'(1))) begin
                    state_nxt = S_SET_PC;
                end
            end
            S_SET_PC: begin
                pc_set_wr = 1'b1;
                state_nxt = clear ? S_LOAD_ADDR : S_RUN;
            end
            S_RUN: begin
                run = 1'b1;
                if (clear) begin
                    state_nxt = S_LOAD_ADDR;
                end else if (core_stop || wd_hit) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                busy     = 1'b0;
                finished = 1'b1;
                if (clear) begin
                    state_nxt = S_LOAD_ADDR;
                end
            end
            default: begin
                state_nxt = S_LOAD_ADDR;
            end
        endcase
    end

    // Load pointer, remaining length, run cycle counter and timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_addr <= '0;
            ptr        <= '0;
            remaining  <= '0;
            cnt        <= '0;
            timeout_q  <= 1'b0;
        end else begin
            case (state)
                S_LOAD_ADDR: begin
                    if (take) begin
                        start_addr <= in_data[AW-1:0];
                        ptr        <= in_data[AW-1:0];
                    end
                end
                S_LOAD_LEN: begin
                    if (take) begin
                        remaining <= len_val;
                    end
                end
                S_LOAD_DATA: begin
                    if (take) begin
                        ptr       <= ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                end
                S_SET_PC: begin
                    if (!clear) begin
                        cnt       <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    cnt <= cnt_plus[15:0];
                    // Core completion outranks the watchdog on the same edge.
                    if (!clear && !core_stop && wd_hit) begin
                        timeout_q <= 1'b1;
                    end
                end
                S_FINISH: begin
                    if (clear) begin
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    // Memory write port: the loader while streaming, the core only while running.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[ptr] <= in_data;
        end else if (proc_wr_en) begin
            mem[proc_addr] <= proc_wdata;
        end
    end

endmodule

// File: tb/tb_simproc_loader.sv
// tb/tb_simproc_loader.sv - directed scoreboard bench for simproc_loader
module tb_simproc_loader;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int MAXC = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          clear;
    logic [AW-1:0] proc_addr;
    logic [DW-1:0] proc_wdata;
    logic          proc_we;
    logic [DW-1:0] proc_rdata;
    logic [AW-1:0] pc_set_val;
    logic          pc_set_wr;
    logic          run;
    logic          proc_done;
    logic          proc_halt;
    logic          busy;
    logic          finished;
    logic          timeout;
    logic [15:0]   cycle_count;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    logic [7:0] img1 [4] = '{8'h90, 8'h44, 8'h47, 8'hA8};
    logic [7:0] img2 [3] = '{8'h11, 8'h22, 8'h33};

    simproc_loader #(.AW(AW), .DW(DW), .MAX_CYCLES(MAXC)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .clear      (clear),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_we    (proc_we),
        .proc_rdata (proc_rdata),
        .pc_set_val (pc_set_val),
        .pc_set_wr  (pc_set_wr),
        .run        (run),
        .proc_done  (proc_done),
        .proc_halt  (proc_halt),
        .busy       (busy),
        .finished   (finished),
        .timeout    (timeout),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_gap(input logic [7:0] b);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) tick();
        send(b);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse_done();
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
    endtask

    task automatic expect_mem(input logic [7:0] a, input logic [7:0] d);
        sb_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            proc_addr = e.addr;
            #1;
            check(tag, proc_rdata, e.data);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] a;
        int n;

        rst = 1'b0; in_data = '0; in_valid = 1'b0; clear = 1'b0;
        proc_addr = '0; proc_wdata = '0; proc_we = 1'b0;
        proc_done = 1'b0; proc_halt = 1'b0;
        repeat (2) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_run", run, 0);
        check("rst_pc_wr", pc_set_wr, 0);
        check("rst_pc_val", pc_set_val, 0);
        check("rst_finished", finished, 0);
        check("rst_timeout", timeout, 0);
        check("rst_count", cycle_count, 0);
        rst = 1'b1;
        tick();

        // Basic load and run terminated by proc_done.
        send(8'h00);
        send(8'h04);
        a = 8'h00;
        for (int i = 0; i < 4; i++) begin
            send(img1[i]);
            expect_mem(a, img1[i]);
            a++;
        end
        check("t1_setpc_wr", pc_set_wr, 1);
        check("t1_setpc_val", pc_set_val, 8'h00);
        check("t1_setpc_run", run, 0);
        check("t1_setpc_busy", busy, 1);
        tick();
        check("t1_run_rise", run, 1);
        check("t1_wr_once", pc_set_wr, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_run_hold", run, 1);
        end
        pulse_done();
        check("t1_run_fall", run, 0);
        check("t1_finished", finished, 1);
        check("t1_timeout", timeout, 0);
        check("t1_count", cycle_count, 6);
        check("t1_fin_ready", in_ready, 0);
        send(8'h99);
        check("t1_fin_ignore", finished, 1);
        drain("t1_mem");
        pulse_clear();
        check("t1_clr_fin", finished, 0);
        check("t1_clr_ready", in_ready, 1);
        check("t1_clr_count", cycle_count, 6);

        // Address wrap past the top of memory, stop via proc_halt.
        send(8'hFE);
        send(8'h03);
        a = 8'hFE;
        for (int i = 0; i < 3; i++) begin
            send(img2[i]);
            expect_mem(a, img2[i]);
            a++;
        end
        check("t2_pc_wr", pc_set_wr, 1);
        check("t2_pc_val", pc_set_val, 8'hFE);
        tick();
        proc_halt = 1'b1;
        tick();
        proc_halt = 1'b0;
        check("t2_finished", finished, 1);
        check("t2_timeout", timeout, 0);
        check("t2_count", cycle_count, 1);
        drain("t2_mem");
        pulse_clear();

        // Length zero means the full 256-byte image.
        send(8'h00);
        send(8'h00);
        for (int k = 0; k < 256; k++) begin
            send(8'(k));
            expect_mem(8'(k), 8'(k));
            if (k == 254) begin
                check("t3_not_yet_wr", pc_set_wr, 0);
                check("t3_not_yet_ready", in_ready, 1);
            end
        end
        check("t3_setpc", pc_set_wr, 1);
        tick();
        pulse_done();
        pulse_clear();
        drain("t3_mem");

        // Clear coinciding with an address byte discards it.
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check("t4_still_addr", busy, 0);
        send(8'h30);
        send(8'h01);
        send(8'hAB);
        expect_mem(8'h30, 8'hAB);
        check("t4_pc_wr", pc_set_wr, 1);
        check("t4_pc_val", pc_set_val, 8'h30);
        tick();
        pulse_done();
        pulse_clear();
        drain("t4_mem");

        // Core writes ignored while loading, honoured while running; clear in RUN.
        send(8'h10);
        send(8'h02);
        proc_we = 1'b1;
        proc_addr = 8'hC0;
        proc_wdata = 8'h5A;
        send(8'h01);
        send(8'h02);
        proc_we = 1'b0;
        expect_mem(8'h10, 8'h01);
        expect_mem(8'h11, 8'h02);
        expect_mem(8'hC0, 8'hC0);
        drain("t5_load_mem");
        tick();
        check("t5_in_run", run, 1);
        proc_addr = 8'hC0;
        proc_wdata = 8'h5A;
        proc_we = 1'b1;
        tick();
        proc_we = 1'b0;
        check("t5_run_write", proc_rdata, 8'h5A);
        pulse_clear();
        check("t5_abort_run", run, 0);
        check("t5_abort_fin", finished, 0);
        check("t5_abort_to", timeout, 0);
        check("t5_abort_ready", in_ready, 1);

        // Watchdog expiry.
        send(8'h20);
        send(8'h01);
        send(8'h77);
        expect_mem(8'h20, 8'h77);
        tick();
        n = 0;
        while (run === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("t6_run_cycles", n, MAXC);
        check("t6_finished", finished, 1);
        check("t6_timeout", timeout, 1);
        check("t6_count", cycle_count, MAXC);
        pulse_clear();
        check("t6_clr_ready", in_ready, 1);
        check("t6_clr_fin", finished, 0);
        check("t6_clr_to", timeout, 0);
        check("t6_clr_count", cycle_count, MAXC);
        drain("t6_mem");

        // Done on the same edge as watchdog expiry: done wins.
        send(8'h21);
        send(8'h01);
        send(8'h88);
        tick();
        repeat (MAXC - 1) tick();
        pulse_done();
        check("t7_finished", finished, 1);
        check("t7_timeout", timeout, 0);
        check("t7_count", cycle_count, MAXC);
        pulse_clear();

        // Reset in the middle of LOAD_DATA with irregular valid gaps.
        send_gap(8'h40);
        send_gap(8'h04);
        send_gap(8'hE1);
        send_gap(8'hE2);
        expect_mem(8'h40, 8'hE1);
        expect_mem(8'h41, 8'hE2);
        expect_mem(8'h42, 8'h42);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("t8_rst_ready", in_ready, 1);
        check("t8_rst_busy", busy, 0);
        check("t8_rst_pc_val", pc_set_val, 0);
        check("t8_rst_count", cycle_count, 0);
        check("t8_rst_run", run, 0);
        drain("t8_mem");
        tick();
        rst = 1'b1;
        tick();
        check("t8_post_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simproc_loader.md
Name: simproc_loader

Overview:
- Program loader and memory owner upstream of the simproc core.
- Accepts a byte stream (start address, length, payload) over a valid/ready handshake and writes it into an internal 2^AW x DW memory.
- Then sets the core's PC, asserts run until the core reports done/halt or a watchdog expires, and holds a status until cleared.
- Serves the core's memory port: combinational read; writes are honoured only while running.

Parameters:
- AW, 8, memory address width (depth 2^AW); also the pc_set_val width.
- DW, 8, memory data width and stream byte width.
- MAX_CYCLES, 1000, watchdog limit on RUN cycles; must be in 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_data  in  DW  stream byte.
- in_valid  in  1  stream byte valid.
- in_ready  out  1  loader can accept a byte.
- clear  in  1  one-cycle pulse: abort, or acknowledge status.
- proc_addr  in  AW  core memory address (core mem_addr).
- proc_wdata  in  DW  core write data (core mem_din).
- proc_we  in  1  core write enable (core mem_we).
- proc_rdata  out  DW  mem[proc_addr], combinational (to core mem_dout).
- pc_set_val  out  AW  PC load value for the core.
- pc_set_wr  out  1  PC load strobe.
- run  out  1  core run enable.
- proc_done  in  1  core done.
- proc_halt  in  1  core halt.
- busy  out  1  high in any state except LOAD_ADDR and FINISH.
- finished  out  1  run completed; status valid.
- timeout  out  1  run ended by watchdog.
- cycle_count  out  16  RUN cycles counted in the last or current run.

Behaviour:
- Reset (rst=0, asynchronous) drives the FSM to LOAD_ADDR.
  - in_ready=1; all other outputs 0 (pc_set_val=0, cycle_count=0).
  - Memory contents are not reset.
- States: LOAD_ADDR -> LOAD_LEN -> LOAD_DATA -> SET_PC -> RUN -> FINISH -> LOAD_ADDR.
- Handshake: a byte is accepted on a rising edge when in_valid&&in_ready. in_ready=1 only in LOAD_ADDR, LOAD_LEN and LOAD_DATA. Gaps on in_valid stall the FSM with no side effects.
- LOAD_ADDR: accepted byte is latched as start_addr and copied into the write pointer.
- LOAD_LEN: accepted byte is the remaining count. 0 means 2^AW bytes.
- LOAD_DATA:
  - Each accepted byte is written to mem[ptr] on the same edge.
  - ptr increments modulo 2^AW (0xFF wraps to 0x00).
  - After the last byte, go to SET_PC.
- SET_PC: lasts exactly 1 cycle. pc_set_wr=1 and pc_set_val=start_addr; run=0. pc_set_val holds start_addr afterwards until the next LOAD_ADDR accept.
- RUN:
  - run=1 and busy=1.
  - cycle_count clears on entry, then increments each RUN cycle.
  - proc_we writes mem[proc_addr]<=proc_wdata.
- RUN exit priority, evaluated each RUN edge:
  1. proc_done or proc_halt: go to FINISH with timeout=0.
  2. cycle_count reaching MAX_CYCLES on this edge: go to FINISH with timeout=1.
- Simultaneous done and watchdog expiry on the same edge: done wins, timeout=0.
- FINISH:
  - run=0 the cycle after exit; finished=1.
  - timeout and cycle_count are held.
  - in_ready=0 and stream bytes are ignored.
  - clear goes to LOAD_ADDR and zeroes finished and timeout; cycle_count is held until the next RUN entry.
- clear in LOAD_LEN, LOAD_DATA, SET_PC or RUN: abort to LOAD_ADDR on that edge.
  - run drops the next cycle.
  - Bytes already written remain in memory.
  - finished and timeout stay 0.
- clear in LOAD_ADDR: no effect. If it coincides with an accept, clear wins and the byte is consumed but discarded.
- proc_we outside RUN is ignored, so the loader is the sole writer while loading.
- proc_rdata is always mem[proc_addr], in every state.
- Reset mid-operation: immediate return to reset values; a partially loaded image is left as-is in memory.

Test Plan:
- Load the stream 00,04,90,44,47,A8, then hold proc_done=0 for 5 cycles and then pulse it. Required response:
  - mem[0..3]=90,44,47,A8.
  - pc_set_wr high for exactly 1 cycle with pc_set_val=00.
  - run rises the next cycle and falls the cycle after done.
  - finished=1, timeout=0, cycle_count=6.
- Stream FE,03,11,22,33 -> mem[FE]=11, mem[FF]=22, mem[00]=33 (wrap); pc_set_val=FE.
- Length byte 00 followed by 256 bytes k=0..255 at start 00 -> mem[k]=k; SET_PC is entered only after the 256th byte.
- MAX_CYCLES=20, proc_done=proc_halt=0 -> run high for 20 cycles, then finished=1, timeout=1, cycle_count=20. A following clear returns to LOAD_ADDR with in_ready=1.
- In RUN, proc_we=1, proc_addr=C0, proc_wdata=5A -> mem[C0]=5A and proc_rdata=5A the next cycle. The same write attempted during LOAD_DATA leaves mem[C0] unchanged.
- Two further cases:
  - Random in_valid gaps plus rst low during LOAD_DATA after 2 of 4 bytes -> outputs go to reset values immediately and in_ready=1.
  - A clear in RUN -> run=0 the next cycle, finished=0.
